rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that turns a multi-bit request vector into a registered, strictly one-hot grant.
- Sits directly upstream of the team's one-hot 8-to-3 / 4-to-2 encoders, which require exactly one input bit high.
- Also provides the encoded grant index and a hold/acknowledge handshake.
- Includes an optional watchdog that forces release of a grant never acknowledged.

---
 rtl/rr_onehot_arbiter.sv | 117 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: multi-bit request vector to a registered one-hot grant,
// with grant index, ack handshake and an optional no-ack watchdog.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    // state | meaning
    // IDLE  | no grant outstanding; arbitrate on req every cycle
    // GRANT | one requester owns the resource until ack or watchdog expiry

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) + 1 : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [N-1:0]     ONE       = N'(1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [N-1:0]       gnt_nxt;
    logic               gnt_valid_nxt;
    logic [IDX_W-1:0]   gnt_idx_nxt;
    logic               timeout_nxt;

    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               expire;

    // N is a power of two, so IDX_W-bit addition wraps the scan modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        gnt_idx_nxt   = gnt_idx;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt       = ONE << win_idx;
                    gnt_valid_nxt = 1'b1;
                    gnt_idx_nxt   = win_idx;
                    hold_cnt_nxt  = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (ack || expire) begin
                    // Going through IDLE guarantees a zero-grant bubble between owners.
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = gnt_idx + 1'b1;
                    timeout_nxt   = !ack;
                    state_nxt     = IDLE;
                end else if (hold_cnt != CNT_SAT) begin
                    hold_cnt_nxt  = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            gnt_idx   <= gnt_idx_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios on an N=8 instance, then
// randomized traffic on N=8 / N=8 no-watchdog / N=4 instances against a queue-free reference.
module tb_rr_onehot_arbiter;

    localparam int MH8 = 16;
    localparam int MH4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] r8, r8z, g8, g8z;
    logic [3:0] r4, g4;
    logic       a8, a8z, a4, v8, v8z, v4, t8, t8z, t4;
    logic [2:0] i8, i8z;
    logic [1:0] i4;

    rr_onehot_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(MH8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(r8), .ack(a8),
        .gnt(g8), .gnt_valid(v8), .gnt_idx(i8), .timeout(t8));

    rr_onehot_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(0)) dut8z (
        .clk(clk), .rst_n(rst_n), .req(r8z), .ack(a8z),
        .gnt(g8z), .gnt_valid(v8z), .gnt_idx(i8z), .timeout(t8z));

    rr_onehot_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(MH4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(r4), .ack(a4),
        .gnt(g4), .gnt_valid(v4), .gnt_idx(i4), .timeout(t4));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: who owns the resource, how long it has held it, and where the scan starts.
    int m_busy [3];
    int m_owner[3];
    int m_ptr  [3];
    int m_age  [3];
    int m_tmo  [3];

    task automatic model_step(input int k, input int n, input int mh,
                              input logic [7:0] rq, input logic ak);
        m_tmo[k] = 0;
        if (m_busy[k] == 0) begin
            for (int j = 0; j < n; j++) begin
                int c;
                c = (m_ptr[k] + j) % n;
                if (rq[c]) begin
                    m_busy[k]  = 1;
                    m_owner[k] = c;
                    m_age[k]   = 0;
                    break;
                end
            end
        end else if (ak) begin
            m_busy[k] = 0;
            m_ptr[k]  = (m_owner[k] + 1) % n;
        end else if (mh != 0 && m_age[k] == mh - 1) begin
            m_busy[k] = 0;
            m_ptr[k]  = (m_owner[k] + 1) % n;
            m_tmo[k]  = 1;
        end else begin
            m_age[k] = m_age[k] + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_age[k] = 0; m_tmo[k] = 0;
            end
        end else begin
            model_step(0, 8, MH8, r8, a8);
            model_step(1, 8, 0, r8z, a8z);
            model_step(2, 4, MH4, {4'b0, r4}, a4);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_dut(input string tag, input int k, input logic [7:0] g,
                             input logic v, input logic [2:0] idx, input logic t);
        logic [7:0] eg;
        int pos;
        eg  = (m_busy[k] != 0) ? (8'h01 << m_owner[k]) : 8'h00;
        pos = 0;
        for (int b = 0; b < 8; b++) if (g[b]) pos = b;
        chk({tag, "_gnt"},    32'(g),   32'(eg));
        chk({tag, "_valid"},  32'(v),   32'(m_busy[k] != 0));
        chk({tag, "_idx"},    32'(idx), 32'(m_owner[k]));
        chk({tag, "_tmo"},    32'(t),   32'(m_tmo[k]));
        chk({tag, "_onehot"}, 32'($countones(g) <= 1), 32'(1));
        if (v) chk({tag, "_enc"}, 32'(idx), 32'(pos));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cnt;
        logic seen, held_bad;
        r8 = 0; r8z = 0; r4 = 0; a8 = 0; a8z = 0; a4 = 0;
        repeat (2) step();
        chk("rst_gnt",   32'(g8), 32'h0);
        chk("rst_valid", 32'(v8), 32'h0);
        chk("rst_idx",   32'(i8), 32'h0);
        chk("rst_tmo",   32'(t8), 32'h0);
        rst_n = 1'b1;

        // rotation with all requesters active
        r8 = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rot_gnt", 32'(g8), 32'h1 << (i % 8));
            chk("rot_idx", 32'(i8), 32'(i % 8));
            a8 = 1; step(); a8 = 0;
            chk("rot_gap", 32'(v8), 32'h0);
        end

        // pointer wrap and skip
        r8 = 8'h40; step();
        chk("wrap_g6", 32'(i8), 32'h6);
        a8 = 1; step(); a8 = 0;
        r8 = 8'h05; step();
        chk("wrap_gnt0", 32'(g8), 32'h01);
        a8 = 1; step(); a8 = 0;
        step();
        chk("skip_gnt2", 32'(g8), 32'h04);
        chk("skip_idx2", 32'(i8), 32'h2);
        a8 = 1; step(); a8 = 0;

        // grant holds after req drops
        r8 = 8'h08; step();
        chk("hold_gnt", 32'(g8), 32'h08);
        r8 = 8'h00;
        repeat (5) begin
            step();
            chk("hold_stable", 32'(g8), 32'h08);
            chk("hold_idx",    32'(i8), 32'h3);
        end
        a8 = 1; step(); a8 = 0;
        chk("hold_release", 32'(g8), 32'h0);

        // watchdog expiry
        r8 = 8'h02; step();
        chk("wd_grant", 32'(i8), 32'h1);
        r8 = 8'h00;
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (!v8) break;
            cnt++;
        end
        chk("wd_len", 32'(cnt), 32'd16);
        chk("wd_tmo", 32'(t8), 32'h1);
        r8 = 8'h06; step();
        chk("wd_tmo_clr", 32'(t8), 32'h0);
        chk("wd_next",    32'(g8), 32'h04);
        a8 = 1; step(); a8 = 0;

        // ack on the expiry edge counts as a normal ack
        r8 = 8'h10; step();
        r8 = 8'h00;
        repeat (15) step();
        chk("ae_hold", 32'(v8), 32'h1);
        a8 = 1; step(); a8 = 0;
        chk("ae_release", 32'(v8), 32'h0);
        chk("ae_no_tmo",  32'(t8), 32'h0);

        // watchdog disabled
        r8z = 8'h02; step();
        chk("nowd_gnt", 32'(g8z), 32'h02);
        r8z = 8'h00;
        seen = 0; held_bad = 0;
        repeat (120) begin
            step();
            if (t8z) seen = 1;
            if (g8z !== 8'h02) held_bad = 1;
        end
        chk("nowd_tmo",  32'(seen),     32'h0);
        chk("nowd_hold", 32'(held_bad), 32'h0);
        a8z = 1; step(); a8z = 0;
        chk("nowd_release", 32'(g8z), 32'h0);

        // asynchronous reset in the middle of a grant
        r8 = 8'h20; step();
        chk("mid_gnt", 32'(g8), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(g8), 32'h0);
        chk("mid_rst_valid", 32'(v8), 32'h0);
        chk("mid_rst_idx",   32'(i8), 32'h0);
        step();
        rst_n = 1'b1;
        r8 = 8'h21; step();
        chk("post_rst_ptr", 32'(g8), 32'h01);
        a8 = 1; step(); a8 = 0;
        r8 = 8'h20; step();
        chk("post_rst_gnt", 32'(g8), 32'h20);
        chk("post_rst_idx", 32'(i8), 32'h5);
        a8 = 1; step(); a8 = 0;
        r8 = 8'h00;

        // randomized traffic against the reference
        repeat (3000) begin
            r8  = 8'($urandom);
            r8z = 8'($urandom);
            r4  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r8 = 8'h00;
            if ($urandom_range(0, 3) == 0) r4 = 4'h0;
            a8  = ($urandom_range(0, 19) == 0);
            a8z = ($urandom_range(0, 7) == 0);
            a4  = ($urandom_range(0, 5) == 0);
            step();
            check_dut("rnd8",  0, g8,  v8,  i8,  t8);
            check_dut("rnd8z", 1, g8z, v8z, i8z, t8z);
            check_dut("rnd4",  2, {4'b0, g4}, v4, {1'b0, i4}, t4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
